bus_arbiter_rr4: RTL and testbench

BUS_ARBITER_RR4 -- requirements
Module: bus_arbiter_rr4

---
 rtl/bus_arbiter_rr4.sv | 103 ++++++++++
 tb/tb_bus_arbiter_rr4.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr4.sv
// Four-master round-robin bus arbiter. An owner keeps a registered one-hot grant
// until it drops its request or until its hold limit expires while another master waits.
module bus_arbiter_rr4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       bus_busy,
    output logic       preempt
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWN   = 1'b1;
    localparam logic [7:0] HOLD_TOP = 8'(MAX_HOLD - 1);

    logic [0:0] state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] last_id_q, last_id_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       preempt_q, preempt_d;

    logic [3:0] others;
    logic [1:0] win_any, win_oth;

    // Round-robin search starting just after 'from'; 'from' itself is tried last.
    function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] from);
        logic [1:0] idx;
        logic [1:0] w;
        w = from;
        for (int d = 4; d >= 1; d--) begin
            idx = from + 2'(d);
            if (mask[idx]) w = idx;
        end
        return w;
    endfunction

    // In OWN, last_id is the owner, so masking the granted bit excludes it.
    assign others  = req & ~grant_q;
    assign win_any = rr_pick(req, last_id_q);
    assign win_oth = rr_pick(others, last_id_q);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_id_d  = last_id_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d    = ST_OWN;
                    grant_d    = 4'b0001 << win_any;
                    last_id_d  = win_any;
                    hold_cnt_d = 8'd0;
                end
            end
            default: begin
                if (!req[last_id_q]) begin
                    if (|others) begin
                        grant_d    = 4'b0001 << win_oth;
                        last_id_d  = win_oth;
                        hold_cnt_d = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = 4'b0000;
                    end
                end else if (hold_cnt_q == HOLD_TOP && |others) begin
                    grant_d    = 4'b0001 << win_oth;
                    last_id_d  = win_oth;
                    hold_cnt_d = 8'd0;
                    preempt_d  = 1'b1;
                end else if (hold_cnt_q != HOLD_TOP) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= 4'b0000;
            last_id_q  <= 2'd3;
            hold_cnt_q <= 8'd0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_id_q  <= last_id_d;
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = last_id_q;
    assign bus_busy = (state_q == ST_OWN);
    assign preempt  = preempt_q;

endmodule

// File: tb/tb_bus_arbiter_rr4.sv
// Bench for bus_arbiter_rr4: directed scenarios plus random traffic, all checked
// against an owner/pointer/hold-count reference model kept in integers.
module tb_bus_arbiter_rr4;

    localparam int MAXH = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       bus_busy;
    logic       preempt;

    int errors = 0;
    int checks = 0;

    bus_arbiter_rr4 #(.MAX_HOLD(MAXH)) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .grant(grant), .grant_id(grant_id), .bus_busy(bus_busy), .preempt(preempt)
    );

    always #5 clk = ~clk;

    // Reference model: owner index (-1 = idle), pointer, hold counter, preempt flag.
    int m_owner = -1;
    int m_last  = 3;
    int m_hold  = 0;
    bit m_pre   = 1'b0;

    function automatic int pick(input logic [3:0] mask, input int from);
        for (int d = 1; d <= 4; d++)
            if (mask[(from + d) % 4]) return (from + d) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] m_grant();
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 3; m_hold = 0; m_pre = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r);
        logic [3:0] oth;
        int w;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            if (r != 4'b0) begin
                w = pick(r, m_last);
                m_owner = w; m_last = w; m_hold = 0;
            end
        end else begin
            oth = r;
            oth[m_owner] = 1'b0;
            if (!r[m_owner]) begin
                if (oth != 4'b0) begin
                    w = pick(oth, m_owner);
                    m_owner = w; m_last = w; m_hold = 0;
                end else begin
                    m_owner = -1;
                end
            end else if (m_hold == MAXH - 1 && oth != 4'b0) begin
                w = pick(oth, m_owner);
                m_owner = w; m_last = w; m_hold = 0; m_pre = 1'b1;
            end else if (m_hold < MAXH - 1) begin
                m_hold++;
            end
        end
    endtask

    task automatic step(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = 4'b0000;
        reset_n = 1'b0;
        #2;
        model_reset();
        reset_n = 1'b1;
    endtask

    // Per-cycle invariants
    logic [3:0] prev_grant = 4'b0000;
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (!$onehot0(grant)) begin
                errors++; $display("FAIL onehot: grant=%b expected one-hot or zero", grant);
            end
            checks++;
            if (bus_busy !== |grant) begin
                errors++; $display("FAIL busy: bus_busy=%b expected %b", bus_busy, |grant);
            end
            checks++;
            if (preempt && (grant == prev_grant || prev_grant == 4'b0)) begin
                errors++; $display("FAIL preempt_change: preempt=1 grant=%b prev=%b expected owner change", grant, prev_grant);
            end
        end
        prev_grant = grant;
    end

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0 || grant_id !== 2'd3 || bus_busy !== 1'b0 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL reset: grant=%b id=%0d busy=%b pre=%b expected 0000/3/0/0", grant, grant_id, bus_busy, preempt);
        end
        checks++;
        if (dut.hold_cnt_q !== 8'd0) begin
            errors++; $display("FAIL reset_hold: hold_cnt=%0d expected 0", dut.hold_cnt_q);
        end
        #2;
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_rr_basic();
        do_reset();
        step(4'b1111);
        checks++;
        if (grant !== 4'b0001 || grant_id !== 2'd0) begin
            errors++; $display("FAIL first_arb: grant=%b id=%0d expected 0001/0", grant, grant_id);
        end
        step(4'b1111);
        step(4'b1111);
        step(4'b1110);
        checks++;
        if (grant !== 4'b0010 || grant_id !== 2'd1 || preempt !== 1'b0) begin
            errors++; $display("FAIL release_handover: grant=%b id=%0d pre=%b expected 0010/1/0", grant, grant_id, preempt);
        end
        step(4'b0000);
        checks++;
        if (grant !== 4'b0000 || grant_id !== 2'd1 || bus_busy !== 1'b0) begin
            errors++; $display("FAIL to_idle: grant=%b id=%0d busy=%b expected 0000/1/0", grant, grant_id, bus_busy);
        end
        step(4'b0000);
        checks++;
        if (grant !== 4'b0000 || grant_id !== 2'd1) begin
            errors++; $display("FAIL idle_stay: grant=%b id=%0d expected 0000/1", grant, grant_id);
        end
    endtask

    task automatic test_preempt();
        do_reset();
        for (int c = 1; c <= 2 * MAXH + 2; c++) begin
            step(4'b0011);
            checks++;
            if (grant !== m_grant() || preempt !== m_pre || grant_id !== 2'(m_last)) begin
                errors++;
                $display("FAIL preempt_seq c%0d: grant=%b pre=%b id=%0d expected %b/%b/%0d", c, grant, preempt, grant_id, m_grant(), m_pre, m_last);
            end
            if (c == MAXH) begin
                checks++;
                if (grant !== 4'b0001 || preempt !== 1'b0) begin
                    errors++; $display("FAIL hold_last: grant=%b pre=%b expected 0001/0", grant, preempt);
                end
            end
            if (c == MAXH + 1) begin
                checks++;
                if (grant !== 4'b0010 || preempt !== 1'b1) begin
                    errors++; $display("FAIL preempt_fire: grant=%b pre=%b expected 0010/1", grant, preempt);
                end
            end
            if (c == MAXH + 2) begin
                checks++;
                if (preempt !== 1'b0) begin
                    errors++; $display("FAIL preempt_pulse: pre=%b expected 0", preempt);
                end
            end
            if (c == 2 * MAXH + 1) begin
                checks++;
                if (grant !== 4'b0001 || preempt !== 1'b1) begin
                    errors++; $display("FAIL preempt_back: grant=%b pre=%b expected 0001/1", grant, preempt);
                end
            end
        end
    endtask

    task automatic test_saturate();
        int bad;
        bad = 0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step(4'b0100);
            if (grant !== 4'b0100 || preempt !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL solo_hold: %0d bad cycles, expected grant=0100 pre=0 always", bad);
        end
        checks++;
        if (dut.hold_cnt_q !== 8'(MAXH - 1)) begin
            errors++; $display("FAIL saturate: hold_cnt=%0d expected %0d", dut.hold_cnt_q, MAXH - 1);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(4'b0100);
        step(4'b1101);
        step(4'b1001);
        checks++;
        if (grant !== 4'b1000 || grant_id !== 2'd3 || preempt !== 1'b0) begin
            errors++; $display("FAIL handover_3: grant=%b id=%0d pre=%b expected 1000/3/0", grant, grant_id, preempt);
        end
        step(4'b0001);
        checks++;
        if (grant !== 4'b0001 || grant_id !== 2'd0) begin
            errors++; $display("FAIL handover_0: grant=%b id=%0d expected 0001/0", grant, grant_id);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(4'b0010);
        step(4'b0010);
        step(4'b0010);
        checks++;
        if (grant !== 4'b0010) begin
            errors++; $display("FAIL own1: grant=%b expected 0010", grant);
        end
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (grant !== 4'b0000 || grant_id !== 2'd3 || bus_busy !== 1'b0) begin
            errors++; $display("FAIL async_reset: grant=%b id=%0d busy=%b expected 0000/3/0", grant, grant_id, bus_busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0000) begin
            errors++; $display("FAIL reset_held: grant=%b expected 0000", grant);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step(4'b0010);
        checks++;
        if (grant !== 4'b0010 || grant_id !== 2'd1) begin
            errors++; $display("FAIL resume: grant=%b id=%0d expected 0010/1", grant, grant_id);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        r = 4'b0000;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            step(r);
            checks++;
            if (grant !== m_grant() || grant_id !== 2'(m_last) || preempt !== m_pre || bus_busy !== (m_owner >= 0)) begin
                errors++;
                $display("FAIL random c%0d req=%b: grant=%b id=%0d pre=%b expected %b/%0d/%b", c, r, grant, grant_id, preempt, m_grant(), m_last, m_pre);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_basic();
        test_preempt();
        test_saturate();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
